// File: rtl/text_console_writer_pkg.sv
// +--------------------------------------------------------------------------+
// | text_console_writer_pkg : geometry, control codes and states shared with |
// | the text scanout stage.                  Rev 1.0                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package text_console_writer_pkg;

  localparam int TXT_COLS  = 80;
  localparam int TXT_ROWS  = 51;
  localparam int TXT_CELLS = TXT_COLS * TXT_ROWS;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BLANK = 8'h20;

  typedef enum logic [1:0] {
    CLEAR_ALL  = 2'd0,
    IDLE       = 2'd1,
    CLEAR_LINE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/text_console_writer.sv
// +--------------------------------------------------------------------------+
// | text_console_writer : turns a CPU byte stream into char RAM writes,      |
// | tracking a cursor and running screen/line clears.      Rev 1.0           |
// +--------------------------------------------------------------------------+
`default_nettype none

module text_console_writer
  import text_console_writer_pkg::*;
#(
  parameter int         COLS  = TXT_COLS,
  parameter int         ROWS  = TXT_ROWS,
  parameter logic [7:0] BLANK = CH_BLANK
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  output logic        in_ready,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [6:0]  cursor_col,
  output logic [5:0]  cursor_row,
  output logic        busy
);

  localparam logic [11:0] c_last_addr = 12'(COLS * ROWS - 1);
  localparam logic [11:0] c_last_col_cnt = 12'(COLS - 1);
  localparam logic [11:0] c_cols = 12'(COLS);
  localparam logic [6:0]  c_last_col = 7'(COLS - 1);
  localparam logic [5:0]  c_last_row = 6'(ROWS - 1);

  state_t      r_state;
  logic [11:0] r_clr_cnt;
  logic [6:0]  r_col;
  logic [5:0]  r_row;
  logic [11:0] r_line_base;

  logic [11:0] w_cur_addr;
  logic        w_is_ctrl;
  logic        w_adv_row;

  assign in_ready   = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign cursor_col = r_col;
  assign cursor_row = r_row;

  assign w_cur_addr = r_line_base + 12'(r_col);
  assign w_is_ctrl  = (in_char == CH_BS) || (in_char == CH_LF) ||
                      (in_char == CH_FF) || (in_char == CH_CR);
  // LF or a printable landing in the last column pushes the cursor down a row
  assign w_adv_row  = (in_char == CH_LF) || (!w_is_ctrl && (r_col == c_last_col));

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= CLEAR_ALL;
      r_clr_cnt   <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_line_base <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= BLANK;
    end else begin
      wr_en <= 1'b0;
      case (r_state)
        CLEAR_ALL: begin
          wr_en     <= 1'b1;
          wr_addr   <= r_clr_cnt;
          wr_data   <= BLANK;
          r_clr_cnt <= r_clr_cnt + 12'd1;
          if (r_clr_cnt == c_last_addr) r_state <= IDLE;
        end
        CLEAR_LINE: begin
          wr_en     <= 1'b1;
          wr_addr   <= r_line_base + r_clr_cnt;
          wr_data   <= BLANK;
          r_clr_cnt <= r_clr_cnt + 12'd1;
          if (r_clr_cnt == c_last_col_cnt) r_state <= IDLE;
        end
        IDLE: begin
          if (in_valid) begin
            case (in_char)
              CH_FF: begin
                // Cell 0 is blanked on the accept edge so the clear spans exactly CELLS cycles
                r_col       <= '0;
                r_row       <= '0;
                r_line_base <= '0;
                wr_en       <= 1'b1;
                wr_addr     <= '0;
                wr_data     <= BLANK;
                r_clr_cnt   <= 12'd1;
                r_state     <= CLEAR_ALL;
              end
              CH_CR, CH_LF: r_col <= '0;
              CH_BS: begin
                if (r_col != '0) begin
                  r_col   <= r_col - 7'd1;
                  wr_en   <= 1'b1;
                  wr_addr <= w_cur_addr - 12'd1;
                  wr_data <= BLANK;
                end
              end
              default: begin
                wr_en   <= 1'b1;
                wr_addr <= w_cur_addr;
                wr_data <= in_char;
                r_col   <= (r_col == c_last_col) ? 7'd0 : r_col + 7'd1;
              end
            endcase
            if (w_adv_row) begin
              if (r_row == c_last_row) begin
                r_row       <= '0;
                r_line_base <= '0;
                r_clr_cnt   <= '0;
                r_state     <= CLEAR_LINE;
              end else begin
                r_row       <= r_row + 6'd1;
                r_line_base <= r_line_base + c_cols;
              end
            end
          end
        end
        default: r_state <= CLEAR_ALL;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_text_console_writer.sv
// +--------------------------------------------------------------------------+
// | tb_text_console_writer : directed self-checking bench for the console    |
// | writer.                                  Rev 1.0                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_text_console_writer;

  logic        pixel_clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  text_console_writer dut (
    .pixel_clk  (pixel_clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_char    (in_char),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {wr_en, wr_addr, wr_data, in_ready}
  task automatic check_wr(input string tag, input logic en, input logic [11:0] addr,
                          input logic [7:0] data, input logic rdy);
    check(tag, {10'd0, wr_en, wr_addr, wr_data, in_ready}, {10'd0, en, addr, data, rdy});
  endtask

  task automatic check_cursor(input string tag, input logic [6:0] col, input logic [5:0] row);
    check(tag, {19'd0, cursor_col, cursor_row}, {19'd0, col, row});
  endtask

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, presents one byte for one edge, then returns in the next cycle
  task automatic send(input logic [7:0] c);
    int n = 0;
    while (!in_ready && n < 5000) begin
      step();
      n++;
    end
    check("ready_before_send", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_char  = c;
    step();
    in_valid = 1'b0;
  endtask

  task automatic full_clear(input string tag, input int first);
    for (int i = first; i < 4080; i++) begin
      step();
      check_wr(tag, 1'b1, 12'(i), 8'h20, (i == 4079));
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_char  = 8'h00;
    step();
    step();
    check_wr("reset_outputs", 1'b0, 12'd0, 8'h20, 1'b0);
    check("reset_busy", {31'd0, busy}, 32'd1);
    check_cursor("reset_cursor", 7'd0, 6'd0);
    rst_n = 1'b1;

    full_clear("init_clear", 0);
    check_cursor("init_cursor", 7'd0, 6'd0);
    check("init_busy", {31'd0, busy}, 32'd0);

    send("H");
    check_wr("wr_H", 1'b1, 12'd0, 8'h48, 1'b1);
    send("i");
    check_wr("wr_i", 1'b1, 12'd1, 8'h69, 1'b1);
    send(8'h0A);
    check_wr("lf_nowrite", 1'b0, 12'd1, 8'h69, 1'b1);
    send("A");
    check_wr("wr_A", 1'b1, 12'd80, 8'h41, 1'b1);
    check_cursor("cursor_after_A", 7'd1, 6'd1);

    send(8'h0D);
    check("cr_nowrite", {31'd0, wr_en}, 32'd0);
    check_cursor("cursor_after_cr", 7'd0, 6'd1);

    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 79; i++) send(".");
    check_cursor("cursor_col79_row3", 7'd79, 6'd3);
    send("Z");
    check_wr("wr_Z_wrap", 1'b1, 12'd319, 8'h5A, 1'b1);
    check_cursor("cursor_after_Z", 7'd0, 6'd4);
    send(8'h08);
    check("bs_col0_nowrite", {31'd0, wr_en}, 32'd0);
    check_cursor("cursor_bs_col0", 7'd0, 6'd4);
    send("Q");
    check_wr("wr_Q", 1'b1, 12'd320, 8'h51, 1'b1);
    send(8'h08);
    check_wr("bs_blank", 1'b1, 12'd320, 8'h20, 1'b1);
    check_cursor("cursor_after_bs", 7'd0, 6'd4);

    for (int i = 0; i < 46; i++) send(8'h0A);
    for (int i = 0; i < 79; i++) send(".");
    check_cursor("cursor_corner", 7'd79, 6'd50);
    send("X");
    check_wr("wr_X_corner", 1'b1, 12'd4079, 8'h58, 1'b0);
    check("busy_clear_line", {31'd0, busy}, 32'd1);
    check_cursor("cursor_after_X", 7'd0, 6'd0);
    // Byte held valid across the line clear must wait for in_ready
    in_valid = 1'b1;
    in_char  = "Y";
    for (int j = 0; j < 80; j++) begin
      step();
      check_wr("clear_line", 1'b1, 12'(j), 8'h20, (j == 79));
    end
    step();
    in_valid = 1'b0;
    check_wr("wr_Y_after_clear", 1'b1, 12'd0, 8'h59, 1'b1);
    check_cursor("cursor_after_Y", 7'd1, 6'd0);

    send("a");
    send("b");
    check_wr("wr_b", 1'b1, 12'd2, 8'h62, 1'b1);
    send(8'h0C);
    check_wr("ff_first", 1'b1, 12'd0, 8'h20, 1'b0);
    check_cursor("cursor_after_ff", 7'd0, 6'd0);
    full_clear("ff_clear", 1);

    send(8'h0C);
    for (int i = 1; i < 1000; i++) step();
    check_wr("pre_rst_addr999", 1'b1, 12'd999, 8'h20, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_wr("async_rst", 1'b0, 12'd0, 8'h20, 1'b0);
    check("async_rst_busy", {31'd0, busy}, 32'd1);
    @(negedge pixel_clk);
    rst_n = 1'b1;
    full_clear("restart_clear", 0);
    check_cursor("final_cursor", 7'd0, 6'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
